// File: rtl/reg8_feeder_pkg.sv
// Shared types and constants for the reg8_feeder pacing stage and its byte FIFO.
package reg8_feeder_pkg;

   localparam int unsigned GAP_W         = 4;
   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StGap
   } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer; full/empty come from the occupancy counter, not pointer equality.
module byte_fifo
   import reg8_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/reg8_feeder.sv
// Paced byte source for the 8-bit register family: FIFO plus IDLE/WRITE/GAP pulse FSM.
// Define REG8_FEEDER_HOLD_EN to add a 'hold' input that stalls new pops from IDLE.
module reg8_feeder
   import reg8_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned GAP   = 1
) (
   input  logic                     clock,
   input  logic                     reset,
`ifdef REG8_FEEDER_HOLD_EN
   input  logic                     hold,
`endif
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     flush,
   output logic                     wr_en,
   output logic [WIDTH-1:0]         wr_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);

   localparam int unsigned      CW       = $clog2(DEPTH) + 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic             hold_active;
   logic             push;
   logic             pop;
   logic             fifo_nonempty;
   logic [WIDTH-1:0] head;

`ifdef REG8_FEEDER_HOLD_EN
   assign hold_active = hold;
`else
   assign hold_active = 1'b0;
`endif

   assign fifo_nonempty = (count != '0);
   assign push_ready    = (count < CW'(DEPTH)) && !flush;
   assign push          = push_valid && push_ready;
   assign busy          = (state != StIdle) || fifo_nonempty;

   // Pop decision is shared by the FIFO and the FSM so both see the same edge.
   always_comb begin
      pop = 1'b0;
      if (!flush) begin
         unique case (state)
            StIdle:  pop = fifo_nonempty && !hold_active;
            StWrite: pop = (GAP == 0) && fifo_nonempty;
            default: pop = 1'b0;
         endcase
      end
   end

   byte_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= StIdle;
         gap_cnt <= '0;
         wr_en   <= 1'b0;
         wr_data <= '0;
      end else if (flush) begin
         // wr_data intentionally keeps the last written byte.
         state   <= StIdle;
         gap_cnt <= '0;
         wr_en   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (pop) begin
                  state   <= StWrite;
                  wr_en   <= 1'b1;
                  wr_data <= head;
               end
            end
            StWrite: begin
               wr_en <= 1'b0;
               if (GAP != 0) begin
                  state   <= StGap;
                  gap_cnt <= GAP_LOAD;
               end else if (pop) begin
                  state   <= StWrite;
                  wr_en   <= 1'b1;
                  wr_data <= head;
               end else begin
                  state <= StIdle;
               end
            end
            StGap: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  state   <= StIdle;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               state   <= StIdle;
               gap_cnt <= '0;
               wr_en   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/reg8_feeder.md
# reg8_feeder

Upstream pacing stage for the 8-bit register family (pe / ner / ll). Accepts bytes on a valid/ready push interface, buffers them in a small circular FIFO, and replays them to a downstream 8-bit register as single-cycle `wr_en` pulses with matching `wr_data`. It replaces hand-written stimulus sequences on the DE0 board and in benches with a paced, back-pressured byte source.

## Interface
- `WIDTH`, 8: data width; must match the downstream register.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `GAP`, 1: idle cycles inserted after each `wr_en` pulse, range 0..15; 0 gives back-to-back pulses.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push_valid`  in  1  producer has a byte on `push_data`.
- `push_ready`  out  1  high when `count < DEPTH` and `flush` is low.
- `push_data`  in  WIDTH  byte to enqueue.
- `flush`  in  1  synchronous clear of FIFO and FSM.
- `wr_en`  out  1  write strobe to the downstream register; registered.
- `wr_data`  out  WIDTH  byte for the downstream register's `in`; registered.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  high when FSM ≠ IDLE or `count ≠ 0`.

## Operation
- A push is accepted on an edge where `push_valid && push_ready`. There is no bypass: a push while full is refused.
- FSM states: IDLE, WRITE, GAP.
- IDLE → WRITE when `count ≠ 0`. On that edge, pop the head: `wr_en` ← 1, `wr_data` ← head.
- WRITE lasts exactly one cycle and clears `wr_en`.
  - If `GAP > 0`: go to GAP and load the gap counter with `GAP`.
  - If `GAP = 0` and FIFO is non-empty: go directly to WRITE again and pop the next byte, giving continuous pulses.
  - Otherwise go to IDLE.
- GAP decrements its counter each cycle. At 1 it goes to IDLE, and IDLE may pop on the following edge.
- A push and a pop on the same edge leave `count` unchanged. Data order is strictly FIFO.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full and empty are derived from `count`, never from pointer equality.
- `flush` has priority over everything:
  - `count` ← 0, pointers ← 0, FSM ← IDLE, `wr_en` ← 0.
  - `push_ready` is low during flush, so no push is accepted that cycle.
  - `wr_data` keeps its last value.
- `wr_data` holds the last written byte between pulses; it is never cleared except by reset.
- Reset values: `wr_en` = 0, `wr_data` = 0, `count` = 0, `push_ready` = 1, `busy` = 0, FSM = IDLE, gap counter = 0.
- Reset mid-operation aborts any pulse immediately, because the reset is asynchronous, and discards FIFO contents.

## Timing
- Push accepted at edge k into an empty, IDLE feeder → `wr_en` high during cycle k+1 (set at edge k+1) with that byte.
- Pulse spacing with a non-empty FIFO: one pulse every `GAP + 2` cycles, except `GAP = 0`, which gives one pulse per cycle.
- `push_ready` rises the cycle after the pop that frees a full FIFO.
- `count` and `busy` are registered or derived from registered state, with no combinational path from `push_valid`.

## Configuration
- `REG8_FEEDER_HOLD_EN` defined: adds input `hold` (1 bit).
  - While `hold` = 1, IDLE does not pop.
  - A WRITE or GAP already in progress completes normally.
  - Pushes continue to be accepted.
- Macro undefined: the `hold` port is absent and the block behaves as if `hold` = 0.

## Structure
- `reg8_feeder_pkg` contains:
  - the `state_t` enum (IDLE, WRITE, GAP);
  - constants `GAP_W` = 4 and the default WIDTH and DEPTH.
- Sub-module `byte_fifo` (WIDTH, DEPTH): circular buffer with push, pop, flush, `count`, and head data. `reg8_feeder` adds the FSM, gap counter, and output registers.

## Test plan
- Reset, push 8'haa at edge k with GAP=1 → `wr_en`=1 and `wr_data`=8'haa during cycle k+1 only; `busy` falls after the GAP cycle.
- GAP=0, push 8'h99, 8'h55, 8'hff back-to-back → three consecutive `wr_en` cycles carrying 99, 55, ff in order.
- DEPTH=4, GAP=3, push 6 bytes continuously → `push_ready` low at `count`=4; all 6 bytes emitted in order, spaced 5 cycles apart.
- Fill with 3 bytes, assert `flush` on an edge where a push is offered → `count`=0, push refused, no further `wr_en`, `wr_data` unchanged.
- Assert `reset` asynchronously in the middle of a WRITE cycle → `wr_en` and `wr_data` go to 0 without waiting for a clock edge; the FIFO is empty after release.
- With `REG8_FEEDER_HOLD_EN`: `hold`=1, push 8'h11 → no `wr_en`, `count`=1; drop `hold` at edge m → `wr_en` with 8'h11 at edge m+1.
